instr_decode_stage: RTL and testbench

// ID stage of the 16-bit pipelined core, between fetch (IF) and execute (EX).

---
 rtl/instr_decode_stage.sv | 115 +++++++++++
 tb/tb_instr_decode_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
// ID stage of the 16-bit pipelined core. Splits the fetched instruction into
// fields, drives the register-file read indices combinationally, computes the
// branch/jump target and control bits, and latches everything into the ID/EX
// pipeline register. Reset loads a NOP bubble into ID/EX.

module instr_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_program_counter_if,
  input  logic [15:0] instruction_if,
  input  logic        branch_prediction_bp,
  input  logic [15:0] reg1_data_rf,
  input  logic [15:0] reg2_data_rf,
  output logic [4:0]  reg1_index_rf,
  output logic [4:0]  reg2_index_rf,
  output logic [3:0]  opcode_id,
  output logic [15:0] target_address_id,
  output logic [15:0] next_program_counter_id,
  output logic [15:0] reg1_data_id,
  output logic [15:0] reg2_data_id,
  output logic [4:0]  dest_reg_index_id,
  output logic [6:0]  immediate_id,
  output logic [3:0]  control_id
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BEQZ = 4'hC,
    OP_BNEZ = 4'hD,
    OP_JMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  opcode_e     opcode;
  logic [4:0]  rd_field;
  logic [6:0]  imm7;
  logic [15:0] target;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        pred_taken;
  logic [4:0]  dest_index;
  logic [3:0]  control;

  assign opcode   = opcode_e'(instruction_if[15:12]);
  assign rd_field = instruction_if[11:7];
  assign imm7     = instruction_if[6:0];

  // The register file is read in the same cycle, so the indices bypass reset
  assign reg1_index_rf = instruction_if[11:7];
  assign reg2_index_rf = instruction_if[6:2];

  // Target is always computed; only branches and jumps use it downstream
  assign target = next_program_counter_if + {{9{imm7[6]}}, imm7};

  // Decode the opcode into write-back, memory and predicted-taken controls
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pred_taken = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_ADDI, OP_LDI: reg_write = 1'b1;
      OP_LD: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OP_ST:            mem_write  = 1'b1;
      OP_BEQZ, OP_BNEZ: pred_taken = branch_prediction_bp;
      OP_JMP:           pred_taken = 1'b1;
      default:          ;
    endcase
  end

  // Non-writing instructions report R0 so hazard logic sees no destination
  assign dest_index = reg_write ? rd_field : 5'd0;
  assign control    = {pred_taken, mem_write, mem_read, reg_write};

  // ID/EX pipeline register; reset inserts a NOP bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_id               <= 4'h0;
      target_address_id       <= 16'h0000;
      next_program_counter_id <= 16'h0000;
      reg1_data_id            <= 16'h0000;
      reg2_data_id            <= 16'h0000;
      dest_reg_index_id       <= 5'd0;
      immediate_id            <= 7'd0;
      control_id              <= 4'h0;
    end else begin
      opcode_id               <= instruction_if[15:12];
      target_address_id       <= target;
      next_program_counter_id <= next_program_counter_if;
      reg1_data_id            <= reg1_data_rf;
      reg2_data_id            <= reg2_data_rf;
      dest_reg_index_id       <= dest_index;
      immediate_id            <= imm7;
      control_id              <= control;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
// Self-checking bench for the ID stage: directed vectors, reset behaviour and
// random instructions compared against a behavioural decode model.

module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] next_program_counter_if;
  logic [15:0] instruction_if;
  logic        branch_prediction_bp;
  logic [15:0] reg1_data_rf;
  logic [15:0] reg2_data_rf;
  logic [4:0]  reg1_index_rf;
  logic [4:0]  reg2_index_rf;
  logic [3:0]  opcode_id;
  logic [15:0] target_address_id;
  logic [15:0] next_program_counter_id;
  logic [15:0] reg1_data_id;
  logic [15:0] reg2_data_id;
  logic [4:0]  dest_reg_index_id;
  logic [6:0]  immediate_id;
  logic [3:0]  control_id;

  int checks = 0;
  int errors = 0;

  // Expected ID/EX contents produced by the model
  logic [3:0]  exp_opcode;
  logic [15:0] exp_target;
  logic [15:0] exp_npc;
  logic [15:0] exp_d1;
  logic [15:0] exp_d2;
  logic [4:0]  exp_dest;
  logic [6:0]  exp_imm;
  logic [3:0]  exp_ctrl;

  instr_decode_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .next_program_counter_if (next_program_counter_if),
    .instruction_if          (instruction_if),
    .branch_prediction_bp    (branch_prediction_bp),
    .reg1_data_rf            (reg1_data_rf),
    .reg2_data_rf            (reg2_data_rf),
    .reg1_index_rf           (reg1_index_rf),
    .reg2_index_rf           (reg2_index_rf),
    .opcode_id               (opcode_id),
    .target_address_id       (target_address_id),
    .next_program_counter_id (next_program_counter_id),
    .reg1_data_id            (reg1_data_id),
    .reg2_data_id            (reg2_data_id),
    .dest_reg_index_id       (dest_reg_index_id),
    .immediate_id            (immediate_id),
    .control_id              (control_id)
  );

  // Free-running pipeline clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Behavioural model: opcode classes and signed arithmetic on the immediate
  task automatic computeExpected(input logic [15:0] instr, input logic [15:0] npc, input logic bp,
                                 input logic [15:0] d1, input logic [15:0] d2);
    int op;
    int imm;
    int tgt;
    bit writes;
    bit loads;
    bit stores;
    bit taken;
    op     = int'(instr[15:12]);
    imm    = int'(instr[6:0]);
    if (imm >= 64) imm = imm - 128;
    tgt    = (int'(npc) + imm + 65536) % 65536;
    writes = (op >= 1 && op <= 10);
    loads  = (op == 10);
    stores = (op == 11);
    taken  = (op == 12 || op == 13) ? bp : (op == 14);
    exp_opcode = 4'(op);
    exp_target = 16'(tgt);
    exp_npc    = npc;
    exp_d1     = d1;
    exp_d2     = d2;
    exp_dest   = writes ? 5'(int'(instr[11:7])) : 5'd0;
    exp_imm    = instr[6:0];
    exp_ctrl   = {taken, stores, loads, writes};
  endtask

  task automatic checkIndices(input string tag, input logic [15:0] instr);
    checkOutput({tag, ".idx1"}, 32'(reg1_index_rf), 32'(int'(instr) / 128 % 32));
    checkOutput({tag, ".idx2"}, 32'(reg2_index_rf), 32'(int'(instr) / 4 % 32));
  endtask

  task automatic checkRegistered(input string tag);
    checkOutput({tag, ".opcode"}, 32'(opcode_id),               32'(exp_opcode));
    checkOutput({tag, ".target"}, 32'(target_address_id),       32'(exp_target));
    checkOutput({tag, ".npc"},    32'(next_program_counter_id), 32'(exp_npc));
    checkOutput({tag, ".d1"},     32'(reg1_data_id),            32'(exp_d1));
    checkOutput({tag, ".d2"},     32'(reg2_data_id),            32'(exp_d2));
    checkOutput({tag, ".dest"},   32'(dest_reg_index_id),       32'(exp_dest));
    checkOutput({tag, ".imm"},    32'(immediate_id),            32'(exp_imm));
    checkOutput({tag, ".ctrl"},   32'(control_id),              32'(exp_ctrl));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".opcode"}, 32'(opcode_id),               32'h0);
    checkOutput({tag, ".target"}, 32'(target_address_id),       32'h0);
    checkOutput({tag, ".npc"},    32'(next_program_counter_id), 32'h0);
    checkOutput({tag, ".d1"},     32'(reg1_data_id),            32'h0);
    checkOutput({tag, ".d2"},     32'(reg2_data_id),            32'h0);
    checkOutput({tag, ".dest"},   32'(dest_reg_index_id),       32'h0);
    checkOutput({tag, ".imm"},    32'(immediate_id),            32'h0);
    checkOutput({tag, ".ctrl"},   32'(control_id),              32'h0);
  endtask

  // Drive one instruction at the falling edge, check indices, then the latch
  task automatic applyStimulus(input string tag, input logic [15:0] instr, input logic [15:0] npc,
                               input logic bp, input logic [15:0] d1, input logic [15:0] d2);
    instruction_if          = instr;
    next_program_counter_if = npc;
    branch_prediction_bp    = bp;
    reg1_data_rf            = d1;
    reg2_data_rf            = d2;
    #1;
    checkIndices(tag, instr);
    computeExpected(instr, npc, bp, d1, d2);
    @(posedge clk);
    #1;
    checkRegistered(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n                   = 1'b0;
    instruction_if          = 16'h0000;
    next_program_counter_if = 16'h0000;
    branch_prediction_bp    = 1'b0;
    reg1_data_rf            = 16'h0000;
    reg2_data_rf            = 16'h0000;
    #2;
    checkAllZero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    applyStimulus("add",    16'h1022, 16'h0001, 1'b0, 16'h0001, 16'h0002);
    checkOutput("add.ctrl_lit", 32'(control_id), 32'b0001);
    checkOutput("add.dest_lit", 32'(dest_reg_index_id), 32'd0);
    applyStimulus("beqz_t", 16'hC07E, 16'h0010, 1'b1, 16'h1234, 16'h5678);
    checkOutput("beqz_t.target_lit", 32'(target_address_id), 32'h000E);
    checkOutput("beqz_t.ctrl_lit", 32'(control_id), 32'b1000);
    applyStimulus("beqz_n", 16'hC07E, 16'h0010, 1'b0, 16'h0000, 16'h0000);
    checkOutput("beqz_n.ctrl_lit", 32'(control_id), 32'b0000);
    applyStimulus("jmp",    16'hE001, 16'hFFFF, 1'b0, 16'hAAAA, 16'h5555);
    checkOutput("jmp.target_lit", 32'(target_address_id), 32'h0000);
    checkOutput("jmp.ctrl_lit", 32'(control_id), 32'b1000);
    applyStimulus("ld",     16'hA288, 16'h0100, 1'b1, 16'h0F0F, 16'hF0F0);
    checkOutput("ld.dest_lit", 32'(dest_reg_index_id), 32'd5);
    checkOutput("ld.ctrl_lit", 32'(control_id), 32'b0011);
    applyStimulus("st",     16'hB288, 16'h0101, 1'b1, 16'h0F0F, 16'hF0F0);
    checkOutput("st.dest_lit", 32'(dest_reg_index_id), 32'd0);
    checkOutput("st.ctrl_lit", 32'(control_id), 32'b0100);
    applyStimulus("bnez",   16'hD7C0, 16'h8000, 1'b1, 16'h0001, 16'h0002);
    applyStimulus("halt",   16'hFFFF, 16'h1234, 1'b1, 16'hBEEF, 16'hCAFE);
    applyStimulus("addi",   16'h8FBF, 16'h0040, 1'b1, 16'h0003, 16'h0004);

    // Reset asserted mid-cycle must clear ID/EX before the next edge
    applyStimulus("pre_rst", 16'h1F85, 16'h2222, 1'b0, 16'h1111, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_async");
    checkIndices("rst_async", instruction_if);
    @(posedge clk);
    #1;
    checkAllZero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAllZero("rst_release");
    computeExpected(instruction_if, next_program_counter_if, branch_prediction_bp,
                    reg1_data_rf, reg2_data_rf);
    @(posedge clk);
    #1;
    checkRegistered("rst_reload");
    @(negedge clk);

    // Random instructions against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 16'($urandom), 16'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
